// File: rtl/adc_axis_packetizer.sv
// Splits the ADC AXI-Stream into packets: one header beat, up to len_q payload beats, tlast on the end.
// Define PKT_TRAILER_EN to append a trailer beat (inverted magic, seq, beats sent) that carries tlast.
module adc_axis_packetizer #(
  parameter int          DATA_WIDTH    = 64,
  parameter int          MAX_PKT_BEATS = 128,
  parameter logic [15:0] HDR_MAGIC     = 16'hADC0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  input  logic                    m_axis_tready,
  input  logic [15:0]             pkt_len_beats,
  output logic [31:0]             pkt_count,
  output logic                    busy
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_BEATS);

`ifdef PKT_TRAILER_EN
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;
`else
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;
`endif

  state_t      state, state_n;
  logic [15:0] len_q;
  logic [15:0] beat_cnt;
  logic [15:0] seq;
  logic        frame_start;
  logic        drain;
  logic        load_hdr, hdr_done, load_trl, pkt_done;
  logic        out_fire, in_fire, is_last;

  function automatic logic [15:0] clamp_len(input logic [15:0] req);
    if (req == 16'd0 || req > MAX_LEN) return MAX_LEN;
    return req;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pack_word(input logic [15:0] tag, input logic [15:0] sq,
                                                      input logic [15:0] len, input logic fs);
    logic [DATA_WIDTH-1:0] w;
    w        = '0;
    w[63:0]  = {tag, sq, len, 15'd0, fs};
    return w;
  endfunction

  assign out_fire      = m_axis_tvalid && m_axis_tready;
  // drain blocks further input once the closing beat is sitting in the output register
  assign s_axis_tready = (state == PAYLOAD) && !drain && (!m_axis_tvalid || m_axis_tready);
  assign in_fire       = s_axis_tvalid && s_axis_tready;
  assign is_last       = (beat_cnt == len_q - 16'd1) || s_axis_tlast;
  assign m_axis_tkeep  = {(DATA_WIDTH/8){m_axis_tvalid}};
  assign busy          = (state != IDLE);

  always_comb begin
    state_n  = state;
    load_hdr = 1'b0;
    hdr_done = 1'b0;
    load_trl = 1'b0;
    pkt_done = 1'b0;
    case (state)
      IDLE: if (s_axis_tvalid) begin
        load_hdr = 1'b1;
        state_n  = HEADER;
      end
      HEADER: if (out_fire) begin
        hdr_done = 1'b1;
        state_n  = PAYLOAD;
      end
      PAYLOAD: if (drain && out_fire) begin
`ifdef PKT_TRAILER_EN
        load_trl = 1'b1;
        state_n  = TRAILER;
`else
        pkt_done = 1'b1;
        state_n  = IDLE;
`endif
      end
`ifdef PKT_TRAILER_EN
      TRAILER: if (out_fire) begin
        pkt_done = 1'b1;
        state_n  = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Output register stage: header, payload or trailer beat, held while stalled
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      len_q         <= MAX_LEN;
      beat_cnt      <= '0;
      seq           <= '0;
      frame_start   <= 1'b1;
      drain         <= 1'b0;
      pkt_count     <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      state <= state_n;
      if (load_hdr) begin
        len_q         <= clamp_len(pkt_len_beats);
        m_axis_tdata  <= pack_word(HDR_MAGIC, seq, clamp_len(pkt_len_beats), frame_start);
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= 1'b0;
      end else if (in_fire) begin
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tvalid <= 1'b1;
`ifdef PKT_TRAILER_EN
        m_axis_tlast  <= 1'b0;
`else
        m_axis_tlast  <= is_last;
`endif
      end else if (load_trl) begin
        m_axis_tdata  <= pack_word(~HDR_MAGIC, seq, beat_cnt, 1'b0);
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= 1'b1;
      end else if (out_fire) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end

      if (hdr_done) begin
        frame_start <= 1'b0;
        beat_cnt    <= '0;
        drain       <= 1'b0;
      end
      if (in_fire) begin
        beat_cnt <= beat_cnt + 16'd1;
        if (s_axis_tlast) frame_start <= 1'b1;
        if (is_last) drain <= 1'b1;
      end
      if (pkt_done) begin
        seq       <= seq + 16'd1;
        pkt_count <= pkt_count + 32'd1;
        drain     <= 1'b0;
      end
    end
  end

endmodule
